// File: rtl/pwm_nivel.sv
// PWM generator that turns the bouncing counter level into LED brightness.
// A run/drain FSM guarantees that disabling always finishes the current period.
module pwm_nivel #(
    parameter int PRESC = 4,
    parameter int WIDTH = 4,
    parameter int PW    = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] nivel,
    output logic             pwm,
    output logic             ativo,
    output logic             fim_periodo,
    output logic [PW-1:0]    periodos
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } estado_t;

    localparam int               PCW       = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PCW-1:0]   PRESC_MAX = PCW'(PRESC - 1);
    localparam logic [WIDTH-1:0] FASE_MAX  = '1;

    estado_t          estado_q;
    logic [PCW-1:0]   presc_q;
    logic [PCW-1:0]   presc_d;
    logic [WIDTH-1:0] fase_q;
    logic [WIDTH-1:0] fase_d;
    logic [WIDTH-1:0] duty_q;
    logic [PW-1:0]    periodos_q;
    logic             fim_q;
    logic             tick;
    logic             wrap;

    assign tick = (estado_q != IDLE) && (presc_q == PRESC_MAX);
    assign wrap = tick && (fase_q == FASE_MAX);

    always_comb begin
        presc_d = tick ? '0 : presc_q + PCW'(1);
        fase_d  = tick ? fase_q + WIDTH'(1) : fase_q;
    end

    // Wrap of fase_d on a wrap edge starts the next period at fase 0 by itself,
    // so DRAIN entry on a wrap edge needs no special handling.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q   <= IDLE;
            presc_q    <= '0;
            fase_q     <= '0;
            duty_q     <= '0;
            periodos_q <= '0;
            fim_q      <= 1'b0;
        end else begin
            fim_q <= wrap;
            if (wrap) begin
                periodos_q <= periodos_q + PW'(1);
            end
            case (estado_q)
                IDLE: begin
                    presc_q <= '0;
                    fase_q  <= '0;
                    if (enable) begin
                        estado_q <= RUN;
                        duty_q   <= nivel;
                    end
                end
                RUN: begin
                    presc_q <= presc_d;
                    fase_q  <= fase_d;
                    if (!enable) begin
                        estado_q <= DRAIN;
                    end else if (wrap) begin
                        duty_q <= nivel;
                    end
                end
                DRAIN: begin
                    presc_q <= presc_d;
                    fase_q  <= fase_d;
                    if (enable) begin
                        estado_q <= RUN;
                        if (wrap) begin
                            duty_q <= nivel;
                        end
                    end else if (wrap) begin
                        estado_q <= IDLE;
                    end
                end
                default: begin
                    estado_q <= IDLE;
                    presc_q  <= '0;
                    fase_q   <= '0;
                end
            endcase
        end
    end

    assign pwm         = (estado_q != IDLE) && (fase_q < duty_q);
    assign ativo       = (estado_q != IDLE);
    assign fim_periodo = fim_q;
    assign periodos    = periodos_q;
endmodule

// File: tb/tb_pwm_nivel.sv
// Directed bench for pwm_nivel with PRESC=4, WIDTH=4: one period is 64 clocks.
module tb_pwm_nivel;
    logic       clock;
    logic       reset;
    logic       enable;
    logic [3:0] nivel;
    logic       pwm;
    logic       ativo;
    logic       fim_periodo;
    logic [7:0] periodos;

    int checks = 0;
    int errors = 0;

    pwm_nivel #(.PRESC(4), .WIDTH(4), .PW(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .nivel       (nivel),
        .pwm         (pwm),
        .ativo       (ativo),
        .fim_periodo (fim_periodo),
        .periodos    (periodos)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Samples one 64-clock window on falling edges; sample 0 is the cycle right
    // after the period-start edge. Optionally changes nivel or drops enable.
    task automatic measure(input int chg_at, input logic [3:0] chg_val, input int drop_at,
                           output int high, output int first_low, output int act_cnt,
                           output int fim_cnt, output logic fim0, output logic [7:0] per0);
        high = 0;
        first_low = 64;
        act_cnt = 0;
        fim_cnt = 0;
        fim0 = 1'b0;
        per0 = '0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            if (pwm) high++;
            else if (first_low == 64) first_low = i;
            if (ativo) act_cnt++;
            if (fim_periodo) fim_cnt++;
            if (i == 0) begin
                fim0 = fim_periodo;
                per0 = periodos;
            end
            if (i == chg_at) nivel = chg_val;
            if (i == drop_at) enable = 1'b0;
        end
    endtask

    task automatic restart(input logic [3:0] nv);
        @(negedge clock);
        reset = 1'b1;
        enable = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        nivel = nv;
        enable = 1'b1;
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b1;
        enable = 1'b0;
        nivel = 4'd0;
        #12;
        checks++;
        if ({pwm, ativo, fim_periodo, periodos} !== 11'd0) begin
            errors++;
            $display("FAIL reset_init: got pwm=%b ativo=%b fim=%b per=%0d expected all 0",
                     pwm, ativo, fim_periodo, periodos);
        end
        @(negedge clock);
        reset = 1'b0;
        nivel = 4'd5;
        enable = 1'b1;
        repeat (70) @(negedge clock);
        checks++;
        if ({pwm, ativo, periodos} !== {1'b1, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL pre_reset_run: got pwm=%b ativo=%b per=%0d expected 1 1 1",
                     pwm, ativo, periodos);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({pwm, ativo, fim_periodo, periodos} !== 11'd0) begin
            errors++;
            $display("FAIL async_reset: got pwm=%b ativo=%b fim=%b per=%0d expected all 0",
                     pwm, ativo, fim_periodo, periodos);
        end
        enable = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        bad = 0;
        repeat (100) begin
            @(negedge clock);
            if ({pwm, ativo, fim_periodo, periodos} !== 11'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL idle_after_reset: got %0d nonzero cycles expected 0", bad);
        end
    endtask

    task automatic test_basic();
        int h, fl, ac, fc;
        logic f0;
        logic [7:0] p0;
        restart(4'd5);
        measure(-1, 4'd0, -1, h, fl, ac, fc, f0, p0);
        checks++;
        if (h !== 20 || fl !== 20) begin
            errors++;
            $display("FAIL basic_p1_high: got high=%0d first_low=%0d expected 20 20", h, fl);
        end
        checks++;
        if (f0 !== 1'b0 || p0 !== 8'd0 || fc !== 0 || ac !== 64) begin
            errors++;
            $display("FAIL basic_p1_acct: got fim0=%b per0=%0d fim_cnt=%0d ativo=%0d expected 0 0 0 64",
                     f0, p0, fc, ac);
        end
        measure(-1, 4'd0, -1, h, fl, ac, fc, f0, p0);
        checks++;
        if (h !== 20 || fl !== 20) begin
            errors++;
            $display("FAIL basic_p2_high: got high=%0d first_low=%0d expected 20 20", h, fl);
        end
        checks++;
        if (f0 !== 1'b1 || p0 !== 8'd1 || fc !== 1) begin
            errors++;
            $display("FAIL basic_p2_acct: got fim0=%b per0=%0d fim_cnt=%0d expected 1 1 1", f0, p0, fc);
        end
    endtask

    task automatic test_levels();
        int h, fl, ac, fc;
        logic f0;
        logic [7:0] p0;
        restart(4'd0);
        measure(-1, 4'd0, -1, h, fl, ac, fc, f0, p0);
        checks++;
        if (h !== 0 || fl !== 0) begin
            errors++;
            $display("FAIL level0_p1: got high=%0d first_low=%0d expected 0 0", h, fl);
        end
        measure(40, 4'd15, -1, h, fl, ac, fc, f0, p0);
        checks++;
        if (h !== 0 || p0 !== 8'd1 || f0 !== 1'b1) begin
            errors++;
            $display("FAIL level0_p2: got high=%0d per0=%0d fim0=%b expected 0 1 1", h, p0, f0);
        end
        measure(-1, 4'd0, -1, h, fl, ac, fc, f0, p0);
        checks++;
        if (h !== 60 || fl !== 60 || p0 !== 8'd2) begin
            errors++;
            $display("FAIL level15: got high=%0d first_low=%0d per0=%0d expected 60 60 2", h, fl, p0);
        end
    endtask

    task automatic test_midchange();
        int h, fl, ac, fc;
        logic f0;
        logic [7:0] p0;
        restart(4'd5);
        measure(30, 4'd10, -1, h, fl, ac, fc, f0, p0);
        checks++;
        if (h !== 20 || fl !== 20) begin
            errors++;
            $display("FAIL midchange_cur: got high=%0d first_low=%0d expected 20 20", h, fl);
        end
        measure(-1, 4'd0, -1, h, fl, ac, fc, f0, p0);
        checks++;
        if (h !== 40 || fl !== 40) begin
            errors++;
            $display("FAIL midchange_next: got high=%0d first_low=%0d expected 40 40", h, fl);
        end
    endtask

    task automatic test_drain();
        int h, fl, ac, fc;
        logic f0;
        logic [7:0] p0;
        restart(4'd8);
        measure(-1, 4'd0, 10, h, fl, ac, fc, f0, p0);
        checks++;
        if (h !== 32 || fl !== 32 || ac !== 64) begin
            errors++;
            $display("FAIL drain_period: got high=%0d first_low=%0d ativo=%0d expected 32 32 64", h, fl, ac);
        end
        measure(-1, 4'd0, -1, h, fl, ac, fc, f0, p0);
        checks++;
        if (f0 !== 1'b1 || p0 !== 8'd1 || fc !== 1) begin
            errors++;
            $display("FAIL drain_acct: got fim0=%b per0=%0d fim_cnt=%0d expected 1 1 1", f0, p0, fc);
        end
        checks++;
        if (h !== 0 || ac !== 0) begin
            errors++;
            $display("FAIL drain_idle: got high=%0d ativo=%0d expected 0 0", h, ac);
        end
    endtask

    task automatic test_counter();
        int h, fl, ac, fc, bad;
        logic f0;
        logic [7:0] p0;
        int lvl[33];
        int v, dir;
        v = 0;
        dir = 1;
        for (int n = 0; n < 33; n++) begin
            lvl[n] = v;
            if (v == 15) dir = -1;
            else if (v == 0) dir = 1;
            v = v + dir;
        end
        restart(4'(lvl[0]));
        bad = 0;
        for (int n = 0; n < 32; n++) begin
            measure(32, 4'(lvl[n+1]), -1, h, fl, ac, fc, f0, p0);
            checks++;
            if (h !== 4 * lvl[n] || p0 !== 8'(n)) begin
                errors++;
                $display("FAIL counter_p%0d: got high=%0d per0=%0d expected %0d %0d",
                         n, h, p0, 4 * lvl[n], n);
            end
        end
        @(negedge clock);
        checks++;
        if (periodos !== 8'd32 || fim_periodo !== 1'b1) begin
            errors++;
            $display("FAIL counter_total: got per=%0d fim=%b expected 32 1", periodos, fim_periodo);
        end
        repeat (256 * 64 - 32 * 64) @(negedge clock);
        checks++;
        if (periodos !== 8'd0 || fim_periodo !== 1'b1) begin
            errors++;
            $display("FAIL periodos_wrap: got per=%0d fim=%b expected 0 1", periodos, fim_periodo);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_levels();
        test_midchange();
        test_drain();
        test_counter();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
